spike_rate_decoder: RTL and testbench

Receive-side counterpart of the spiking-neuron core: it takes the spike outputs that the neuron pair drives off-chip (pre/post spikes) and decodes them back into numbers. For each channel, it reports a spike count and a minimum inter-spike interval per programmable time window. Results leave through a valid/ready output register. Counting continues while a result waits to be consumed.

---
 rtl/snn_pkg.sv | 15 +
 rtl/spike_chan_acc.sv | 66 ++++++
 rtl/spike_rate_decoder.sv | 108 ++++++++++
 tb/tb_spike_rate_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and default widths for the spike-rate decoder.
// Window FSM states and the "no interval seen" marker.
package snn_pkg;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;

  localparam logic [WIN_W-1:0] ISI_NONE = '1;

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

endpackage

// File: rtl/spike_chan_acc.sv
// One spike channel: edge detect, saturating count, min interval.
// cnt_o/min_isi_o already include an event on the current cycle.
module spike_chan_acc #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_i,
  input  logic             clear_i,
  input  logic             active_i,
  input  logic [WIN_W-1:0] cyc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [WIN_W-1:0] min_isi_o
);

  logic             spike_q;
  logic             ev;
  logic             has_q, has_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0] last_q, last_d;
  logic [WIN_W-1:0] min_q, min_d;
  logic [WIN_W-1:0] isi;

  always_comb begin
    ev     = spike_i & ~spike_q & active_i;
    isi    = cyc_i - last_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    has_d  = has_q;
    min_d  = min_q;
    if (ev) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      last_d = cyc_i;
      has_d  = 1'b1;
      if (has_q && (isi < min_q)) min_d = isi;
    end
  end

  assign cnt_o     = cnt_d;
  assign min_isi_o = min_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_q <= 1'b0;
      has_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
      min_q   <= '1;
    end else begin
      spike_q <= spike_i;
      if (clear_i) begin
        has_q  <= 1'b0;
        cnt_q  <= '0;
        last_q <= '0;
        min_q  <= '1;
      end else begin
        has_q  <= has_d;
        cnt_q  <= cnt_d;
        last_q <= last_d;
        min_q  <= min_d;
      end
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes off-chip spike trains into per-window counts and min ISI.
// Window FSM, cycle counter and a valid/ready result register.
module spike_rate_decoder #(
  parameter int NCH   = 2,
  parameter int CNT_W = snn_pkg::CNT_W,
  parameter int WIN_W = snn_pkg::WIN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       spike_in,
  input  logic [WIN_W-1:0]     win_len,
  input  logic                 run,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*CNT_W-1:0] out_count,
  output logic [NCH*WIN_W-1:0] out_min_isi,
  output logic                 overrun
);

  import snn_pkg::*;

  state_e               state_q, state_d;
  logic [WIN_W-1:0]     cyc_q, cyc_d;
  logic [WIN_W-1:0]     len_q, len_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic [NCH*CNT_W-1:0] cnt_q, cnt_nx;
  logic [NCH*WIN_W-1:0] isi_q, isi_nx;
  logic                 cnting;
  logic                 close;
  logic                 start;
  logic                 load;

  assign cnting = (state_q == COUNT);
  assign close  = cnting && (cyc_q == len_q - 1'b1);
  assign start  = run && (!cnting || close);
  assign load   = close && (!valid_q || out_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (run) state_d = COUNT;
      COUNT: if (close && !run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_d = cyc_q;
    len_d = len_q;
    if (start) begin
      cyc_d = '0;
      len_d = (win_len == '0) ? WIN_W'(1) : win_len;
    end else if (cnting) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  // A close loading alongside a handshake keeps out_valid high.
  assign valid_d = load || (valid_q && !out_ready);
  assign ovr_d   = ovr_q || (close && valid_q && !out_ready);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    spike_chan_acc #(
      .CNT_W(CNT_W),
      .WIN_W(WIN_W)
    ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .spike_i  (spike_in[k]),
      .clear_i  (start),
      .active_i (cnting),
      .cyc_i    (cyc_q),
      .cnt_o    (cnt_nx[k*CNT_W +: CNT_W]),
      .min_isi_o(isi_nx[k*WIN_W +: WIN_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      len_q   <= WIN_W'(1);
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      isi_q   <= '1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      if (load) begin
        cnt_q <= cnt_nx;
        isi_q <= isi_nx;
      end
    end
  end

  assign busy        = cnting;
  assign out_valid   = valid_q;
  assign overrun     = ovr_q;
  assign out_count   = cnt_q;
  assign out_min_isi = isi_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: event-list model plus directed pins.
// Random traffic with back-pressure follows the directed scenarios.
module tb_spike_rate_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  spike_in = '0;
  logic [15:0] win_len = '0;
  logic        run = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, out_valid, overrun;
  logic [15:0] out_count;
  logic [31:0] out_min_isi;

  spike_rate_decoder #(
    .NCH(2), .CNT_W(8), .WIN_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .win_len    (win_len),
    .run        (run),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_min_isi(out_min_isi),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: window membership plus the list of event times per channel
  bit          m_in;
  int          m_t, m_len;
  bit [1:0]    m_prev;
  int          evq [2][$];
  bit          m_valid, m_ovr;
  bit [15:0]   m_cnt;
  bit [31:0]   m_isi;

  function automatic void model_reset();
    m_in = 0; m_t = 0; m_len = 1; m_prev = '0;
    evq[0].delete(); evq[1].delete();
    m_valid = 0; m_ovr = 0;
    m_cnt = '0; m_isi = '1;
  endfunction

  function automatic void model_start();
    m_in = 1; m_t = 0;
    m_len = (win_len == 0) ? 1 : int'(win_len);
    evq[0].delete(); evq[1].delete();
  endfunction

  function automatic void model_result();
    int n, c, best, d;
    for (int k = 0; k < 2; k++) begin
      n = evq[k].size();
      c = (n > 255) ? 255 : n;
      best = 16'hFFFF;
      for (int i = 1; i < n; i++) begin
        d = evq[k][i] - evq[k][i-1];
        if (d < best) best = d;
      end
      m_cnt[k*8 +: 8]  = 8'(c);
      m_isi[k*16 +: 16] = 16'(best);
    end
  endfunction

  function automatic void model_edge();
    bit [1:0] ev;
    bit close, hs;
    if (rst) begin
      model_reset();
      return;
    end
    ev = spike_in & ~m_prev;
    m_prev = spike_in;
    hs = m_valid && out_ready;
    close = 0;
    if (m_in) begin
      for (int k = 0; k < 2; k++)
        if (ev[k]) evq[k].push_back(m_t);
      if (m_t == m_len - 1) close = 1;
      else m_t++;
    end else if (run) begin
      model_start();
    end
    if (close) begin
      if (!m_valid || out_ready) begin
        model_result();
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
      if (run) model_start();
      else m_in = 0;
    end else if (hs) begin
      m_valid = 0;
    end
  endfunction

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_in));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("out_count", 64'(out_count), 64'(m_cnt));
    chk("out_min_isi", 64'(out_min_isi), 64'(m_isi));
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(bit r, bit [1:0] s, bit rd);
    run = r;
    spike_in = s;
    out_ready = rd;
    step();
  endtask

  initial begin
    model_reset();
    repeat (2) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_isi", 64'(out_min_isi), 64'hFFFF_FFFF);
    rst = 1'b0;

    // three pulses in a 10-cycle window
    win_len = 16'd10;
    drv(1, 2'b00, 0);
    for (int i = 0; i < 10; i++)
      drv(0, (i == 2 || i == 5 || i == 9) ? 2'b01 : 2'b00, 0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_cnt0", 64'(out_count[7:0]), 64'd3);
    chk("t1_isi0", 64'(out_min_isi[15:0]), 64'd3);
    chk("t1_cnt1", 64'(out_count[15:8]), 64'd0);
    chk("t1_isi1", 64'(out_min_isi[31:16]), 64'hFFFF);
    drv(0, 2'b00, 1);
    chk("t1_consumed", 64'(out_valid), 64'd0);

    // held level counts once; interval is rise-to-rise
    win_len = 16'd20;
    drv(1, 2'b00, 0);
    for (int i = 0; i < 20; i++)
      drv(0, (i < 4 || i == 7) ? 2'b01 : 2'b00, 0);
    chk("t2_cnt0", 64'(out_count[7:0]), 64'd2);
    chk("t2_isi0", 64'(out_min_isi[15:0]), 64'd7);
    drv(0, 2'b00, 1);

    // count saturation
    win_len = 16'd600;
    drv(1, 2'b00, 0);
    for (int i = 0; i < 600; i++)
      drv(0, (i % 2 == 1) ? 2'b01 : 2'b00, 0);
    chk("t3_sat", 64'(out_count[7:0]), 64'd255);
    chk("t3_isi0", 64'(out_min_isi[15:0]), 64'd2);
    drv(0, 2'b00, 1);

    // overrun, then load coinciding with handshake
    win_len = 16'd3;
    drv(1, 2'b00, 0);
    drv(1, 2'b01, 0); drv(1, 2'b00, 0); drv(1, 2'b00, 0);
    chk("t4_w1_cnt", 64'(out_count[7:0]), 64'd1);
    drv(1, 2'b01, 0); drv(1, 2'b00, 0); drv(1, 2'b01, 0);
    chk("t4_ovr", 64'(overrun), 64'd1);
    chk("t4_kept", 64'(out_count[7:0]), 64'd1);
    drv(0, 2'b00, 0); drv(0, 2'b00, 0); drv(0, 2'b00, 1);
    chk("t4_stay_valid", 64'(out_valid), 64'd1);
    chk("t4_new_cnt", 64'(out_count[7:0]), 64'd0);
    chk("t4_new_isi", 64'(out_min_isi[15:0]), 64'hFFFF);
    drv(0, 2'b00, 1);
    chk("t4_consumed", 64'(out_valid), 64'd0);

    // close-cycle and first-cycle spikes land in their own windows
    win_len = 16'd4;
    drv(1, 2'b00, 1);
    drv(1, 2'b00, 1); drv(1, 2'b00, 1);
    drv(1, 2'b00, 1); drv(1, 2'b01, 1);
    chk("t5_n_cnt0", 64'(out_count[7:0]), 64'd1);
    chk("t5_n_cnt1", 64'(out_count[15:8]), 64'd0);
    drv(0, 2'b10, 1);
    drv(0, 2'b00, 1); drv(0, 2'b00, 1); drv(0, 2'b00, 1);
    chk("t5_n1_cnt0", 64'(out_count[7:0]), 64'd0);
    chk("t5_n1_cnt1", 64'(out_count[15:8]), 64'd1);

    // win_len 0 behaves as 1-cycle windows
    win_len = 16'd0;
    drv(1, 2'b00, 1);
    drv(1, 2'b01, 1);
    chk("t5_w0_cnt", 64'(out_count[7:0]), 64'd1);
    chk("t5_w0_busy", 64'(busy), 64'd1);
    drv(0, 2'b00, 1);
    chk("t5_w0_cnt2", 64'(out_count[7:0]), 64'd0);
    chk("t5_w0_idle", 64'(busy), 64'd0);
    drv(0, 2'b00, 1);

    // asynchronous reset mid-window
    win_len = 16'd20;
    drv(1, 2'b00, 1);
    for (int i = 0; i < 6; i++)
      drv(0, (i % 2 == 0) ? 2'b01 : 2'b00, 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_ovr", 64'(overrun), 64'd0);
    chk("t6_cnt", 64'(out_count), 64'd0);
    chk("t6_isi", 64'(out_min_isi), 64'hFFFF_FFFF);
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++)
      drv(0, 2'($urandom), 1);
    chk("t6_no_result", 64'(out_valid), 64'd0);

    // random traffic with back-pressure
    for (int i = 0; i < 4000; i++) begin
      win_len = ($urandom_range(0, 19) == 0) ?
                16'($urandom_range(0, 60)) :
                16'($urandom_range(0, 8));
      drv($urandom_range(0, 9) != 0, 2'($urandom),
          $urandom_range(0, 2) == 0);
    end
    drv(0, 2'b00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
